// File: rtl/smi_tx_ctrl.sv
// smi_tx_ctrl: SMI host write-side controller.
// Collects four SMI byte writes into a 32-bit word (MSB first) and pushes it
// into the 0.9 GHz (address 000) or 2.4 GHz (address 001) TX FIFO.
// A small control-register bus exposes the module version and a status byte.
// Optional build macro: SMI_TX_OVERFLOW_CNT_EN adds per-channel 8-bit
// saturating dropped-word counters at ioc 5'b00010 / 5'b00011.
//
// Handshake note: a push strobe is a one-cycle pulse issued only when the
// selected FIFO reported not-full during the push state; there is no
// back-pressure after the pulse, so the FIFO must accept every pulse.
// The host must keep the strobe low across reset release; the strobe
// synchronizer powers up at 0, so a strobe held high through reset release
// would be seen as a write event.
module smi_tx_ctrl #(
    parameter logic [7:0] MODULE_VERSION = 8'h01
) (
    input  logic        i_sys_clk,
    input  logic        i_reset_n,
    input  logic [4:0]  i_ioc,
    input  logic        i_cs,
    input  logic        i_fetch_cmd,
    output logic [7:0]  o_data_out,
    input  logic [2:0]  i_smi_a,
    input  logic        i_smi_swe_srw,
    input  logic [7:0]  i_smi_data_in,
    output logic        o_smi_write_req,
    output logic        o_fifo_09_push,
    output logic [31:0] o_fifo_09_push_data,
    input  logic        i_fifo_09_full,
    output logic        o_fifo_24_push,
    output logic [31:0] o_fifo_24_push_data,
    input  logic        i_fifo_24_full,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_B0   = 3'd0,
        ST_B1   = 3'd1,
        ST_B2   = 3'd2,
        ST_B3   = 3'd3,
        ST_PUSH = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  swe_q;
    logic [2:0]  a_s1;
    logic [2:0]  a_s2;
    logic [7:0]  d_s1;
    logic [7:0]  d_s2;

    logic        ch_q;      // 0 = channel 09, 1 = channel 24
    logic [31:0] word_q;

    logic        addr_err_q;
    logic        ovf09_q;
    logic        ovf24_q;

    logic        smi_event;
    logic        addr_ok;
    logic        ev_valid;
    logic        ev_bad;
    logic        ev_ch;
    logic        load_first;
    logic        load_next;
    logic        sel_full;
    logic        do_push;
    logic        do_drop;
    logic        rd_cmd;
    logic        status_rd;
    logic [7:0]  status;

    assign smi_event = (swe_q[2:1] == 2'b01);
    assign addr_ok   = (a_s2[2:1] == 2'b00);
    assign ev_valid  = smi_event && addr_ok;
    assign ev_bad    = smi_event && !addr_ok;
    assign ev_ch     = a_s2[0];
    assign sel_full  = ch_q ? i_fifo_24_full : i_fifo_09_full;
    assign do_push   = (state_q == ST_PUSH) && !sel_full;
    assign do_drop   = (state_q == ST_PUSH) && sel_full;
    assign rd_cmd    = i_cs && i_fetch_cmd;
    assign status_rd = rd_cmd && (i_ioc == 5'b00001);
    assign status    = {3'b000, addr_err_q, ovf24_q, ovf09_q,
                        i_fifo_24_full, i_fifo_09_full};
    assign o_dbg_state = state_q;

    // Synchronize the strobe (3 flops) and the address/data buses (2 flops).
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            swe_q <= 3'b000;
            a_s1  <= 3'b000;
            a_s2  <= 3'b000;
            d_s1  <= 8'h00;
            d_s2  <= 8'h00;
        end else begin
            swe_q <= {swe_q[1:0], i_smi_swe_srw};
            a_s1  <= i_smi_a;
            a_s2  <= a_s1;
            d_s1  <= i_smi_data_in;
            d_s2  <= d_s1;
        end
    end

    // Byte-assembly FSM state register.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_B0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and byte-load decode; a channel switch mid-word restarts at byte0.
    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        load_next  = 1'b0;
        unique case (state_q)
            ST_B0: begin
                if (ev_valid) begin
                    load_first = 1'b1;
                    state_d    = ST_B1;
                end
            end
            ST_B1, ST_B2, ST_B3: begin
                if (ev_valid) begin
                    if (ev_ch != ch_q) begin
                        load_first = 1'b1;
                        state_d    = ST_B1;
                    end else begin
                        load_next = 1'b1;
                        if (state_q == ST_B1) begin
                            state_d = ST_B2;
                        end else if (state_q == ST_B2) begin
                            state_d = ST_B3;
                        end else begin
                            state_d = ST_PUSH;
                        end
                    end
                end
            end
            ST_PUSH: begin
                state_d = ST_B0;
            end
            default: begin
                state_d = ST_B0;
            end
        endcase
    end

    // Word assembly, most significant byte first.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ch_q   <= 1'b0;
            word_q <= 32'h0;
        end else if (load_first) begin
            ch_q   <= ev_ch;
            word_q <= {d_s2, 24'h000000};
        end else if (load_next) begin
            case (state_q)
                ST_B1:   word_q[23:16] <= d_s2;
                ST_B2:   word_q[15:8]  <= d_s2;
                default: word_q[7:0]   <= d_s2;
            endcase
        end
    end

    // Registered push strobes; push data only changes together with a push.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fifo_09_push      <= 1'b0;
            o_fifo_24_push      <= 1'b0;
            o_fifo_09_push_data <= 32'h0;
            o_fifo_24_push_data <= 32'h0;
        end else begin
            o_fifo_09_push <= do_push && !ch_q;
            o_fifo_24_push <= do_push && ch_q;
            if (do_push && !ch_q) begin
                o_fifo_09_push_data <= word_q;
            end
            if (do_push && ch_q) begin
                o_fifo_24_push_data <= word_q;
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a status read wins.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_err_q <= 1'b0;
            ovf09_q    <= 1'b0;
            ovf24_q    <= 1'b0;
        end else begin
            addr_err_q <= ev_bad | (addr_err_q & ~status_rd);
            ovf09_q    <= (do_drop && !ch_q) | (ovf09_q & ~status_rd);
            ovf24_q    <= (do_drop && ch_q) | (ovf24_q & ~status_rd);
        end
    end

    // Write request tells the host whether the addressed FIFO has room.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_smi_write_req <= 1'b0;
        end else begin
            case (a_s2)
                3'b000:  o_smi_write_req <= !i_fifo_09_full;
                3'b001:  o_smi_write_req <= !i_fifo_24_full;
                default: o_smi_write_req <= 1'b0;
            endcase
        end
    end

`ifdef SMI_TX_OVERFLOW_CNT_EN
    logic [7:0] cnt09_q;
    logic [7:0] cnt24_q;

    // Saturating dropped-word counters, cleared only by reset.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt09_q <= 8'h00;
            cnt24_q <= 8'h00;
        end else begin
            if (do_drop && !ch_q && (cnt09_q != 8'hFF)) begin
                cnt09_q <= cnt09_q + 8'h01;
            end
            if (do_drop && ch_q && (cnt24_q != 8'hFF)) begin
                cnt24_q <= cnt24_q + 8'h01;
            end
        end
    end
`endif

    // Control-register read port; unknown ioc codes leave the output unchanged.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data_out <= 8'h00;
        end else if (rd_cmd) begin
            case (i_ioc)
                5'b00000: o_data_out <= MODULE_VERSION;
                5'b00001: o_data_out <= status;
`ifdef SMI_TX_OVERFLOW_CNT_EN
                5'b00010: o_data_out <= cnt09_q;
                5'b00011: o_data_out <= cnt24_q;
`endif
                default:  o_data_out <= o_data_out;
            endcase
        end
    end

endmodule

// File: tb/tb_smi_tx_ctrl.sv
// Testbench for smi_tx_ctrl: directed scenarios plus randomized byte traffic,
// checked against a byte-list reference model with per-FIFO expected queues.
module tb_smi_tx_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ioc;
    logic        cs;
    logic        fetch;
    logic [7:0]  data_out;
    logic [2:0]  smi_a;
    logic        swe;
    logic [7:0]  smi_d;
    logic        write_req;
    logic        push09;
    logic [31:0] push09_data;
    logic        full09;
    logic        push24;
    logic [31:0] push24_data;
    logic        full24;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues and reference model state.
    logic [31:0] exp_q09[$];
    logic [31:0] exp_q24[$];
    logic [7:0]  m_bytes[$];
    int          m_ch;
    logic        m_addr_err;
    logic        m_ovf09;
    logic        m_ovf24;
    int          m_cnt09;
    int          m_cnt24;
    logic [7:0]  m_dout;

    smi_tx_ctrl dut (
        .i_sys_clk           (clk),
        .i_reset_n           (rst_n),
        .i_ioc               (ioc),
        .i_cs                (cs),
        .i_fetch_cmd         (fetch),
        .o_data_out          (data_out),
        .i_smi_a             (smi_a),
        .i_smi_swe_srw       (swe),
        .i_smi_data_in       (smi_d),
        .o_smi_write_req     (write_req),
        .o_fifo_09_push      (push09),
        .o_fifo_09_push_data (push09_data),
        .i_fifo_09_full      (full09),
        .o_fifo_24_push      (push24),
        .o_fifo_24_push_data (push24_data),
        .i_fifo_24_full      (full24),
        .o_dbg_state         (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every push strobe pops the matching expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (push09 && push24) chk("dual_push", 32'd1, 32'd0);
            if (push09) begin
                if (exp_q09.size() == 0) chk("push09_unexpected", push09_data, 32'hxxxxxxxx);
                else chk("push09_data", push09_data, exp_q09.pop_front());
            end
            if (push24) begin
                if (exp_q24.size() == 0) chk("push24_unexpected", push24_data, 32'hxxxxxxxx);
                else chk("push24_data", push24_data, exp_q24.pop_front());
            end
        end
    end

    function automatic void model_reset();
        m_bytes.delete();
        m_ch       = 0;
        m_addr_err = 1'b0;
        m_ovf09    = 1'b0;
        m_ovf24    = 1'b0;
        m_cnt09    = 0;
        m_cnt24    = 0;
        m_dout     = 8'h00;
    endfunction

    // Reference: bytes collect per channel; a channel change restarts the word.
    function automatic void model_byte(input int a, input logic [7:0] d);
        logic [31:0] w;
        if (a > 1) begin
            m_addr_err = 1'b1;
        end else begin
            if (m_bytes.size() != 0 && a != m_ch) m_bytes.delete();
            m_ch = a;
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                if (a == 0) begin
                    if (full09) begin
                        m_ovf09 = 1'b1;
                        if (m_cnt09 < 255) m_cnt09++;
                    end else exp_q09.push_back(w);
                end else begin
                    if (full24) begin
                        m_ovf24 = 1'b1;
                        if (m_cnt24 < 255) m_cnt24++;
                    end else exp_q24.push_back(w);
                end
            end
        end
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        swe   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_push", {30'h0, push09, push24}, 32'h0);
        chk("rst_push_data", push09_data | push24_data, 32'h0);
        chk("rst_write_req", {31'h0, write_req}, 32'h0);
        chk("rst_state", {29'h0, dbg_state}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Driver: one SMI byte write with write_req check after the address settles.
    task automatic write_byte(input int a, input logic [7:0] d);
        logic exp_req;
        @(posedge clk);
        #1;
        smi_a = a[2:0];
        smi_d = d;
        repeat (3) @(posedge clk);
        #1;
        exp_req = (a == 0) ? !full09 : (a == 1) ? !full24 : 1'b0;
        chk("write_req", {31'h0, write_req}, {31'h0, exp_req});
        model_byte(a, d);
        swe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        swe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Register read; expected value comes from the model, status read clears stickies.
    task automatic read_reg(input logic [4:0] a, input string name);
        logic [7:0] e;
        e = m_dout;
        case (a)
            5'b00000: e = 8'h01;
            5'b00001: e = {3'b000, m_addr_err, m_ovf24, m_ovf09, full24, full09};
`ifdef SMI_TX_OVERFLOW_CNT_EN
            5'b00010: e = m_cnt09[7:0];
            5'b00011: e = m_cnt24[7:0];
`endif
            default:  e = m_dout;
        endcase
        @(posedge clk);
        #1;
        ioc = a; cs = 1'b1; fetch = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0; fetch = 1'b0;
        chk(name, {24'h0, data_out}, {24'h0, e});
        m_dout = e;
        if (a == 5'b00001) begin
            m_addr_err = 1'b0; m_ovf09 = 1'b0; m_ovf24 = 1'b0;
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] w);
        write_byte(a, w[31:24]);
        write_byte(a, w[23:16]);
        write_byte(a, w[15:8]);
        write_byte(a, w[7:0]);
    endtask

    initial begin
        rst_n = 1'b0; ioc = 5'b0; cs = 1'b0; fetch = 1'b0;
        smi_a = 3'b0; swe = 1'b0; smi_d = 8'h0; full09 = 1'b0; full24 = 1'b0;
        model_reset();
        do_reset();

        read_reg(5'b00000, "version");
        read_reg(5'b00001, "status_idle");

        // Single word to 0.9 GHz FIFO.
        write_word(0, 32'h11223344);

        // 2.4 GHz FIFO full: drop and overflow flag.
        full24 = 1'b1;
        write_word(1, 32'h55667788);
        read_reg(5'b00001, "status_ovf24");
        read_reg(5'b00001, "status_ovf24_clr");
        full24 = 1'b0;

        // Channel switch mid-word discards the partial word.
        write_byte(0, 8'h99);
        write_byte(0, 8'h98);
        write_word(1, 32'hAABBCCDD);

        // Invalid address: flag only, no state change.
        write_byte(5, 8'h77);
        read_reg(5'b00001, "status_addr_err");
        write_word(0, 32'hCAFEF00D);

        // Hold on an unknown register code (counter read when built with the option).
        read_reg(5'b00010, "ioc2_read");
        read_reg(5'b00111, "ioc7_hold");

        // Reset in the middle of a word.
        write_byte(0, 8'hE1);
        write_byte(0, 8'hE2);
        write_byte(0, 8'hE3);
        do_reset();
        write_word(0, 32'h01020304);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            int r;
            int a;
            r = $urandom_range(0, 9);
            a = (r < 4) ? 0 : (r < 8) ? 1 : $urandom_range(2, 7);
            full09 = ($urandom_range(0, 3) == 0);
            full24 = ($urandom_range(0, 3) == 0);
            write_byte(a, 8'($urandom_range(0, 255)));
            if (i % 8 == 7) read_reg(5'b00001, "status_rand");
        end
        full09 = 1'b0; full24 = 1'b0;
        read_reg(5'b00001, "status_rand_end");

`ifdef SMI_TX_OVERFLOW_CNT_EN
        // Saturation of the 0.9 GHz dropped-word counter.
        full09 = 1'b1;
        for (int i = 0; i < 300; i++) write_word(0, $urandom);
        full09 = 1'b0;
        read_reg(5'b00010, "cnt09_sat");
        read_reg(5'b00011, "cnt24");
`endif

        repeat (10) @(posedge clk);
        chk("q09_drained", exp_q09.size(), 32'd0);
        chk("q24_drained", exp_q24.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smi_tx_ctrl.md
SMI_TX_CTRL -- requirements
Module: smi_tx_ctrl

Interface
REQ-001 SHALL have parameter MODULE_VERSION, default 8'h01, value returned at ioc 5'b00000.
REQ-002 SHALL have port i_sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_ioc in 5, i_cs in 1, i_fetch_cmd in 1, o_data_out out 8: control-register read bus.
REQ-005 SHALL have ports i_smi_a in 3, i_smi_swe_srw in 1, i_smi_data_in in 8: SMI host write side.
REQ-006 SHALL have port o_smi_write_req  out  1  room available in the TX FIFO addressed by i_smi_a.
REQ-007 SHALL have ports o_fifo_09_push out 1, o_fifo_09_push_data out 32, i_fifo_09_full in 1: 0.9 GHz TX FIFO.
REQ-008 SHALL have ports o_fifo_24_push out 1, o_fifo_24_push_data out 32, i_fifo_24_full in 1: 2.4 GHz TX FIFO.

Function
REQ-009 SHALL pass i_smi_swe_srw through a 3-flop shift register; write event = rising edge on stages [2:1] (2'b01).
REQ-010 SHALL pass i_smi_a and i_smi_data_in through 2-flop registers and sample them in the write-event cycle.
REQ-011 SHALL treat an event with sampled address 3'b000 as channel 09, 3'b001 as channel 24, and all other addresses as ignored, setting sticky addr_err.
REQ-012 SHALL run the FSM ST_B0 -> ST_B1 -> ST_B2 -> ST_B3 -> ST_PUSH -> ST_B0, advancing one byte state per valid event.
REQ-013 SHALL latch the channel at ST_B0 and assemble bytes MSB first: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
REQ-014 SHALL, on a valid event in ST_B1..ST_B3 whose channel differs from the latched one, discard the partial word, store the byte as byte0 of the new channel, and move to ST_B1.
REQ-015 SHALL spend exactly one cycle in ST_PUSH, entered the cycle after the byte3 event.
REQ-016 SHALL, in ST_PUSH with the selected FIFO not full, pulse that FIFO's push for one cycle with the 32-bit word on push_data.
REQ-017 SHALL, in ST_PUSH with the selected FIFO full, drop the word with no push and set that channel's sticky overflow flag.
REQ-018 SHALL never assert both push strobes in the same cycle; push_data holds its last value when push is low.
REQ-019 SHALL rely on events being at least 2 cycles apart, so no event can coincide with ST_PUSH.
REQ-020 SHALL drive o_smi_write_req registered, as !full of the FIFO chosen by the synchronized address; 0 for invalid addresses.
REQ-021 SHALL, on i_cs && i_fetch_cmd, load o_data_out next cycle:
- ioc 5'b00000: MODULE_VERSION
- ioc 5'b00001: status {3'b0, addr_err, ovf24, ovf09, fifo_24_full, fifo_09_full}
- other ioc: hold
REQ-022 SHALL clear sticky flags on a status read; a set event in that same cycle wins.

Reset
REQ-023 SHALL, while i_reset_n=0, force FSM=ST_B0, both push strobes=0, push_data=0, o_data_out=0, o_smi_write_req=0, sticky flags=0, sync registers=0.
REQ-024 SHALL discard any partial word when reset asserts mid-word and push nothing afterwards.
REQ-025 SHALL require, after reset release, a fresh low-to-high strobe transition before the first event.

Configuration
REQ-026 SHALL, with SMI_TX_OVERFLOW_CNT_EN defined, include an 8-bit saturating counter of dropped words per channel, readable at ioc 5'b00010 (ch09) and 5'b00011 (ch24), cleared by reset only.
REQ-027 SHALL, without SMI_TX_OVERFLOW_CNT_EN, omit the counters and treat ioc 5'b00010/5'b00011 as "other ioc" (hold).

Verification
REQ-028 SHALL verify: 4 strobes at a=000 with bytes 11,22,33,44, fifo not full -> single o_fifo_09_push pulse, data 32'h11223344, fifo_24 untouched.
REQ-029 SHALL verify: 4 strobes at a=001 with i_fifo_24_full=1 -> no push, status read returns 8'h0A, second read returns 8'h02.
REQ-030 SHALL verify: 2 bytes at a=000, then 4 bytes AA,BB,CC,DD at a=001 -> one push on 24 with 32'hAABBCCDD, no 09 push.
REQ-031 SHALL verify: strobe at a=101 -> no state change, status bit4=1, o_smi_write_req=0.
REQ-032 SHALL verify: 3 bytes at a=000, pulse i_reset_n low, then 4 bytes 01,02,03,04 -> single push with 32'h01020304.
REQ-033 SHALL verify: with SMI_TX_OVERFLOW_CNT_EN, 300 dropped words on ch09 -> ioc 5'b00010 reads 8'hFF.
